seq_accumulator: RTL and testbench

Multi-cycle accumulator that sits directly upstream and downstream of the 16-bit combinational carry-lookahead adder. It drives the adder's operands and carry-in, then registers the adder's sum and carry-out as the next operand. It takes a stream of operands over a valid/ready handshake and computes init ± Σ operands over a programmed count. It returns the result with a sticky carry/borrow flag over a second valid/ready handshake.

---
 rtl/seq_accumulator_pkg.sv | 16 +
 rtl/seq_accumulator_cla.sv | 52 +++++
 rtl/seq_accumulator.sv | 104 ++++++++++
 tb/tb_seq_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_accumulator_pkg.sv
// Shared definitions for the sequential accumulator and its companion adder.
package seq_accumulator_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_accumulator_cla.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group lookahead.
module seq_accumulator_cla
    import seq_accumulator_pkg::*;
(
    input  logic [DATA_W_DEF-1:0] a_i,
    input  logic [DATA_W_DEF-1:0] b_i,
    input  logic                  cin_i,
    output logic [DATA_W_DEF-1:0] sum_o,
    output logic                  cout_o
);

    // Carries into each of four positions from generate/propagate and carry-in.
    function automatic logic [3:0] cla_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [15:0] g_bit;
    logic [15:0] p_bit;
    logic [3:0]  g_grp;
    logic [3:0]  p_grp;
    logic [3:0]  c_grp;
    logic [15:0] c_bit;

    assign g_bit = a_i & b_i;
    assign p_bit = a_i ^ b_i;

    // Group generate/propagate, group carries, then bit carries inside each group.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            g_grp[k] = g_bit[4*k+3]
                     | (p_bit[4*k+3] & g_bit[4*k+2])
                     | (p_bit[4*k+3] & p_bit[4*k+2] & g_bit[4*k+1])
                     | (p_bit[4*k+3] & p_bit[4*k+2] & p_bit[4*k+1] & g_bit[4*k]);
            p_grp[k] = &p_bit[4*k +: 4];
        end
        c_grp = cla_carries(g_grp, p_grp, cin_i);
        for (int k = 0; k < 4; k++) begin
            c_bit[4*k +: 4] = cla_carries(g_bit[4*k +: 4], p_bit[4*k +: 4], c_grp[k]);
        end
    end

    assign sum_o  = p_bit ^ c_bit;
    assign cout_o = g_grp[3] | (p_grp[3] & c_grp[3]);

endmodule

// File: rtl/seq_accumulator.sv
// Multi-cycle accumulator driving an external adder: init +/- sum of operands.
module seq_accumulator
    import seq_accumulator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sub,
    input  logic [DATA_W-1:0] init,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              mode_q, mode_d;

    // Subtraction is acc + ~op + 1, so a missing carry-out means a borrow.
    logic              beat_ovf;
    assign beat_ovf = (mode_q == MODE_SUB) ? ~add_cout : add_cout;

    // State and datapath registers; reset discards any partial accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
            mode_q  <= MODE_ADD;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: latch job at start, fold in one operand per accepted beat.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = init;
                    ovf_d   = 1'b0;
                    rem_d   = count;
                    mode_d  = sub;
                    state_d = (count == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | beat_ovf;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Adder operands: accumulator plus operand or its one's complement with carry-in.
    assign add_a   = acc_q;
    assign add_b   = (mode_q == MODE_SUB) ? ~in_data : in_data;
    assign add_cin = mode_q;

    // Handshake flags decode the state only, so in_ready never depends on in_valid.
    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_accumulator.sv
// Scoreboard bench for seq_accumulator wired to the carry-lookahead adder.
module tb_seq_accumulator;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] init = '0;
    logic [7:0]  count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    int          nvec = 0;
    int          nmis = 0;
    exp_t        sb_q[$];
    logic [15:0] ops[8];

    always #5 clk = ~clk;

    seq_accumulator #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .init(init),
        .count(count), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    seq_accumulator_cla adder (
        .a_i(add_a), .b_i(add_b), .cin_i(add_cin), .sum_o(add_sum), .cout_o(add_cout)
    );

    // Reference: unsigned wrap-around accumulation with sticky carry/borrow.
    function automatic exp_t model(input logic s, input logic [15:0] ini, input int n);
        exp_t        e;
        logic [16:0] t;
        e.sum = ini;
        e.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!s) begin
                t = {1'b0, e.sum} + {1'b0, ops[i]};
                e.ovf = e.ovf | t[16];
                e.sum = t[15:0];
            end else begin
                if (e.sum < ops[i]) e.ovf = 1'b1;
                e.sum = e.sum - ops[i];
            end
        end
        return e;
    endfunction

    // Start a job, push its expected result, and feed the operands with optional gaps.
    task automatic drive_txn(input logic s, input logic [15:0] ini, input int n,
                             input int gap_pct, input bit noisy, output bit ok);
        int i;
        int guard;
        bit take;
        sb_q.push_back(model(s, ini, n));
        @(posedge clk); #1;
        start = 1'b1; sub = s; init = ini; count = n[7:0];
        @(posedge clk); #1;
        start = noisy;
        if (noisy) begin
            init = 16'hAAAA; count = 8'd1; sub = ~s;
        end
        i = 0;
        guard = 0;
        while (i < n && guard < 500) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = in_valid ? ops[i] : 16'($urandom);
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) i++;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        ok = (i == n);
    endtask

    // Accept the result as soon as it appears, within a bounded wait.
    task automatic collect(output logic [15:0] s, output logic o, output bit found);
        found = 1'b0;
        s = 'x;
        o = 1'bx;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && !found; k++) begin
            if (out_valid) begin
                s = out_sum; o = out_ovf; found = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        nvec++; if (out_sum !== 16'h0) begin nmis++; $display("FAIL reset_out_sum got=%h want=0000", out_sum); end
        nvec++; if (out_ovf !== 1'b0) begin nmis++; $display("FAIL reset_out_ovf got=%b want=0", out_ovf); end
        nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got=%b want=0", busy); end
        nvec++; if (add_cin !== 1'b0) begin nmis++; $display("FAIL reset_add_cin got=%b want=0", add_cin); end
        rst_n = 1'b1;
    endtask

    // One complete job: check beat delivery, next-cycle out_valid, and the result.
    task automatic test_job(input string name, input logic s, input logic [15:0] ini,
                            input int n, input int gap_pct);
        bit          ok;
        bit          found;
        logic [15:0] rs;
        logic        ro;
        exp_t        e;
        drive_txn(s, ini, n, gap_pct, 1'b0, ok);
        nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL %s_beats got=%b want=1", name, ok); end
        nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL %s_latency out_valid got=%b want=1", name, out_valid); end
        collect(rs, ro, found);
        e = sb_q.pop_front();
        nvec++; if (found !== 1'b1) begin nmis++; $display("FAIL %s_timeout got=%b want=1", name, found); end
        nvec++; if (rs !== e.sum) begin nmis++; $display("FAIL %s_sum got=%h want=%h", name, rs, e.sum); end
        nvec++; if (ro !== e.ovf) begin nmis++; $display("FAIL %s_ovf got=%b want=%b", name, ro, e.ovf); end
    endtask

    task automatic test_add();
        ops[0] = 16'h0001; ops[1] = 16'h0002; ops[2] = 16'h0003;
        test_job("add", 1'b0, 16'h0000, 3, 0);
        ops[0] = 16'h0010; ops[1] = 16'h0005;
        test_job("add_wrap", 1'b0, 16'hFFF0, 2, 0);
    endtask

    task automatic test_sub();
        ops[0] = 16'h0010; ops[1] = 16'h0020;
        test_job("sub", 1'b1, 16'h0100, 2, 0);
        ops[0] = 16'h0006;
        test_job("sub_borrow", 1'b1, 16'h0005, 1, 0);
    endtask

    task automatic test_count_zero();
        bit          found;
        logic [15:0] rs;
        logic        ro;
        exp_t        e;
        sb_q.push_back(model(1'b0, 16'h1234, 0));
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; init = 16'h1234; count = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL cnt0_latency out_valid got=%b want=1", out_valid); end
        in_valid = 1'b1; in_data = 16'h7777;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        nvec++; if (out_sum !== sb_q[0].sum) begin nmis++; $display("FAIL cnt0_ignore_beats got=%h want=%h", out_sum, sb_q[0].sum); end
        collect(rs, ro, found);
        e = sb_q.pop_front();
        nvec++; if (rs !== e.sum || found !== 1'b1) begin nmis++; $display("FAIL cnt0_sum got=%h want=%h", rs, e.sum); end
        nvec++; if (ro !== e.ovf) begin nmis++; $display("FAIL cnt0_ovf got=%b want=%b", ro, e.ovf); end
        nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL cnt0_idle busy got=%b want=0", busy); end
    endtask

    // Gapped input, then result held under out_ready=0 while start pokes at DONE.
    task automatic test_backpressure();
        bit          ok;
        bit          found;
        logic [15:0] rs;
        logic        ro;
        exp_t        e;
        for (int i = 0; i < 6; i++) ops[i] = 16'($urandom);
        drive_txn(1'b0, 16'($urandom), 6, 40, 1'b0, ok);
        nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL bp_beats got=%b want=1", ok); end
        start = 1'b1; init = 16'h5555; count = 8'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", k, out_valid); end
            nvec++; if (out_sum !== sb_q[0].sum) begin nmis++; $display("FAIL bp_hold_sum cyc=%0d got=%h want=%h", k, out_sum, sb_q[0].sum); end
        end
        start = 1'b0;
        collect(rs, ro, found);
        e = sb_q.pop_front();
        nvec++; if (rs !== e.sum || found !== 1'b1) begin nmis++; $display("FAIL bp_sum got=%h want=%h", rs, e.sum); end
        nvec++; if (ro !== e.ovf) begin nmis++; $display("FAIL bp_ovf got=%b want=%b", ro, e.ovf); end
    endtask

    task automatic test_start_ignored();
        bit          ok;
        bit          found;
        logic [15:0] rs;
        logic        ro;
        exp_t        e;
        for (int i = 0; i < 4; i++) ops[i] = 16'($urandom_range(0, 16'h0400));
        drive_txn(1'b1, 16'h0800, 4, 30, 1'b1, ok);
        nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL startign_beats got=%b want=1", ok); end
        collect(rs, ro, found);
        e = sb_q.pop_front();
        nvec++; if (rs !== e.sum || found !== 1'b1) begin nmis++; $display("FAIL startign_sum got=%h want=%h", rs, e.sum); end
        nvec++; if (ro !== e.ovf) begin nmis++; $display("FAIL startign_ovf got=%b want=%b", ro, e.ovf); end
    endtask

    // Abort after two of four beats, then confirm a clean job from a new init.
    task automatic test_mid_reset();
        ops[0] = 16'h1111; ops[1] = 16'h2222; ops[2] = 16'h3333; ops[3] = 16'h4444;
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; init = 16'h0100; count = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = ops[i];
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        in_data = ops[2];
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            begin nmis++; $display("FAIL midrst_flags got=%b%b%b want=000", in_ready, out_valid, busy); end
        nvec++; if (out_sum !== 16'h0 || out_ovf !== 1'b0)
            begin nmis++; $display("FAIL midrst_result got=%h/%b want=0000/0", out_sum, out_ovf); end
        test_job("midrst_fresh", 1'b0, 16'h0042, 4, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_count_zero();
        test_backpressure();
        test_start_ignored();
        test_mid_reset();
        nvec++; if (sb_q.size() != 0) begin nmis++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
